cla_result_checker: RTL



---
 rtl/cla_result_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cla_result_checker.sv
// Checks carry-lookahead adder result vectors (S, P, G, Cout) against recomputed expected values.
// Latency: an accepted vector is registered, compared the next cycle, and its counters are visible 2 cycles after acceptance.
// Backpressure: vec_ready is high only in RUN while fewer than num_vectors have been accepted; vec_valid without vec_ready is ignored.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, num_vectors     begin a run of num_vectors checks (ignored while busy)
//   vec_valid, vec_ready   vector handshake
//   A, B, Cin              adder operands
//   S, P, G, Cout          adder outputs under check
//   busy, done, pass       run status
//   vec_count, err_count   vectors compared / vectors with any mismatch
//   first_fail_idx/flags   index and {S,P,G,Cout} mismatch flags of the first failing vector
module cla_result_checker #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_vectors,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] G,
  input  logic             Cout,
  output logic             vec_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      vec_count,
  output logic [15:0]      err_count,
  output logic [15:0]      first_fail_idx,
  output logic [3:0]       first_fail_flags
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]      num_lat;
  logic [15:0]      acc_count;

  // Stage 1: registered copy of the accepted vector
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a, s1_b, s1_s, s1_p, s1_g;
  logic             s1_cin, s1_cout;

  logic [WIDTH:0]   exp_sum;
  logic [3:0]       flags;
  logic             bad;
  logic             accept;
  logic             start_ok;
  logic             last_cmp;

  // Comparison on the stage-1 copy
  always_comb begin
    exp_sum = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
    flags   = {s1_s    != exp_sum[WIDTH-1:0],
               s1_p    != (s1_a ^ s1_b),
               s1_g    != (s1_a & s1_b),
               s1_cout != exp_sum[WIDTH]};
    bad     = s1_vld && (flags != 4'b0000);
  end

  always_comb begin
    vec_ready = (state == RUN) && (acc_count < num_lat);
    accept    = vec_valid && vec_ready;
    start_ok  = start && (state != RUN);
    // num_lat >= 1 in RUN and vec_count < num_lat, so the +1 cannot wrap
    last_cmp  = s1_vld && ((vec_count + 16'd1) == num_lat);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_vectors == 16'd0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_cmp) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_count == 16'd0);
        if (start) state_nxt = (num_vectors == 16'd0) ? DONE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: stage-1 capture and result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat          <= 16'd0;
      acc_count        <= 16'd0;
      s1_vld           <= 1'b0;
      s1_a             <= '0;
      s1_b             <= '0;
      s1_s             <= '0;
      s1_p             <= '0;
      s1_g             <= '0;
      s1_cin           <= 1'b0;
      s1_cout          <= 1'b0;
      vec_count        <= 16'd0;
      err_count        <= 16'd0;
      first_fail_idx   <= 16'hFFFF;
      first_fail_flags <= 4'b0000;
    end else if (start_ok) begin
      num_lat          <= num_vectors;
      acc_count        <= 16'd0;
      s1_vld           <= 1'b0;
      vec_count        <= 16'd0;
      err_count        <= 16'd0;
      first_fail_idx   <= 16'hFFFF;
      first_fail_flags <= 4'b0000;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a      <= A;
        s1_b      <= B;
        s1_cin    <= Cin;
        s1_s      <= S;
        s1_p      <= P;
        s1_g      <= G;
        s1_cout   <= Cout;
        acc_count <= acc_count + 16'd1;
      end
      if (s1_vld) begin
        vec_count <= vec_count + 16'd1;
        if (bad) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          // A failure always has a nonzero flag, so zero flags means none recorded yet
          if (first_fail_flags == 4'b0000) begin
            first_fail_idx   <= vec_count;
            first_fail_flags <= flags;
          end
        end
      end
    end
  end

endmodule
